// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run-control / performance-counter unit:
// run-state encodings, fixed counter indices and small helpers.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    RC_IDLE = 2'd0,
    RC_RUN  = 2'd1,
    RC_STEP = 2'd2,
    RC_HALT = 2'd3
  } run_state_e;

  // Counter 0 always counts advancing cycles; counter i counts evt[i-1].
  localparam int CNT_CYCLES = 0;

  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Connection bundle between the datapath/board logic (master) and the
// run-control unit (slave).
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int N_EVT = 4,
  parameter int SEL_W = 3
);
  logic             go;
  logic             step_mode;
  logic             step_req;
  logic             resume;
  logic             halt_req;
  logic             led_req;
  logic [N_EVT-1:0] evt;
  logic             cnt_clr;
  logic [SEL_W-1:0] cnt_sel;
  logic [CNT_W-1:0] cnt_rd;
  logic             pc_enable;
  logic             led_enable;
  logic [1:0]       run_state;

  modport master (
    output go, step_mode, step_req, resume, halt_req, led_req, evt, cnt_clr, cnt_sel,
    input  cnt_rd, pc_enable, led_enable, run_state
  );

  modport slave (
    input  go, step_mode, step_req, resume, halt_req, led_req, evt, cnt_clr, cnt_sel,
    output cnt_rd, pc_enable, led_enable, run_state
  );
endinterface

// File: rtl/cpu_run_ctrl_perf_counter.sv
// Single event counter with synchronous clear; wraps to zero or holds at
// all-ones depending on SAT.
module cpu_run_ctrl_perf_counter #(
  parameter int CNT_W = 32,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if ((SAT != 0) && (&v)) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // Clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= bump(q);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run control (free-run / single-step / syscall halt and resume) plus a bank
// of performance counters with a registered readout mux.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int N_EVT = 4,
  parameter int SEL_W = 3,
  parameter int SAT   = 0
) (
  input logic           clk,
  input logic           rst,
  cpu_run_ctrl_if.slave bus
);

  localparam int N_CNT = N_EVT + 1;
  localparam int N_SEL = 2 ** SEL_W;

  run_state_e       state_q;
  logic             step_q;
  logic             ovr_q;
  logic             halt_gate;
  logic             step_edge;
  logic             pc_en;
  logic [N_EVT:0]   inc;
  logic [CNT_W-1:0] cnt_q  [N_CNT];
  logic [CNT_W-1:0] rd_mux [N_SEL];
  logic [CNT_W-1:0] rd_p1;

  // ovr lets exactly one advance slip past a halting syscall after resume.
  always_comb begin
    halt_gate = !bus.halt_req || ovr_q;
    step_edge = rise(bus.step_req, step_q);
    pc_en     = 1'b0;
    unique case (state_q)
      RC_RUN:  pc_en = halt_gate;
      RC_STEP: pc_en = step_edge && halt_gate;
      default: pc_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RC_IDLE;
      step_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      step_q <= bus.step_req;
      if (pc_en) begin
        ovr_q <= 1'b0;
      end
      unique case (state_q)
        RC_IDLE: begin
          if (bus.go) begin
            state_q <= bus.step_mode ? RC_STEP : RC_RUN;
          end
        end
        RC_RUN: begin
          if (bus.halt_req && !ovr_q) begin
            state_q <= RC_HALT;
          end else if (!bus.go) begin
            state_q <= RC_IDLE;
          end else if (bus.step_mode) begin
            state_q <= RC_STEP;
          end
        end
        RC_STEP: begin
          if (bus.halt_req && !ovr_q) begin
            state_q <= RC_HALT;
          end else if (!bus.go) begin
            state_q <= RC_IDLE;
          end else if (!bus.step_mode) begin
            state_q <= RC_RUN;
          end
        end
        RC_HALT: begin
          if (!bus.go) begin
            state_q <= RC_IDLE;
            ovr_q   <= 1'b0;
          end else if (bus.resume) begin
            state_q <= bus.step_mode ? RC_STEP : RC_RUN;
            ovr_q   <= 1'b1;
          end
        end
        default: state_q <= RC_IDLE;
      endcase
    end
  end

  // Events of stalled (non-advancing) cycles are not counted.
  assign inc[CNT_CYCLES] = pc_en;
  assign inc[N_EVT:1]    = bus.evt & {N_EVT{pc_en}};

  for (genvar i = 0; i < N_CNT; i++) begin : g_cnt
    cpu_run_ctrl_perf_counter #(
      .CNT_W(CNT_W),
      .SAT  (SAT)
    ) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(bus.cnt_clr),
      .inc(inc[i]),
      .q  (cnt_q[i])
    );
  end

  // Unused select codes read back as zero.
  for (genvar k = 0; k < N_SEL; k++) begin : g_rd
    if (k < N_CNT) begin : g_live
      assign rd_mux[k] = cnt_q[k];
    end else begin : g_zero
      assign rd_mux[k] = '0;
    end
  end

  // p1: registered readout of the pre-update counter value
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_p1 <= '0;
    end else begin
      rd_p1 <= rd_mux[bus.cnt_sel];
    end
  end

  assign bus.pc_enable  = pc_en;
  assign bus.led_enable = bus.led_req & pc_en;
  assign bus.run_state  = state_q;
  assign bus.cnt_rd     = rd_p1;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: table of vectors plus directed sequences, checked
// against a cycle model through an expected-result queue.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.CNT_W(32), .N_EVT(4), .SEL_W(3)) ifm ();
  cpu_run_ctrl_if #(.CNT_W(4),  .N_EVT(4), .SEL_W(3)) ifs ();
  cpu_run_ctrl_if #(.CNT_W(4),  .N_EVT(4), .SEL_W(3)) ifw ();

  assign ifs.go = ifm.go;               assign ifw.go = ifm.go;
  assign ifs.step_mode = ifm.step_mode; assign ifw.step_mode = ifm.step_mode;
  assign ifs.step_req = ifm.step_req;   assign ifw.step_req = ifm.step_req;
  assign ifs.resume = ifm.resume;       assign ifw.resume = ifm.resume;
  assign ifs.halt_req = ifm.halt_req;   assign ifw.halt_req = ifm.halt_req;
  assign ifs.led_req = ifm.led_req;     assign ifw.led_req = ifm.led_req;
  assign ifs.evt = ifm.evt;             assign ifw.evt = ifm.evt;
  assign ifs.cnt_clr = ifm.cnt_clr;     assign ifw.cnt_clr = ifm.cnt_clr;
  assign ifs.cnt_sel = ifm.cnt_sel;     assign ifw.cnt_sel = ifm.cnt_sel;

  cpu_run_ctrl #(.CNT_W(32), .N_EVT(4), .SEL_W(3), .SAT(0)) dut   (.clk(clk), .rst(rst), .bus(ifm));
  cpu_run_ctrl #(.CNT_W(4),  .N_EVT(4), .SEL_W(3), .SAT(1)) dut_s (.clk(clk), .rst(rst), .bus(ifs));
  cpu_run_ctrl #(.CNT_W(4),  .N_EVT(4), .SEL_W(3), .SAT(0)) dut_w (.clk(clk), .rst(rst), .bus(ifw));

  // ctl bits: {go, step_mode, step_req, resume, halt_req, led_req}
  typedef struct {
    logic [5:0] ctl;
    logic [3:0] evt;
    logic       clr;
    logic [2:0] sel;
    logic [1:0] exp_pc_led;
    logic [1:0] exp_nxt;
  } vec_t;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] rd;
  } exp_t;

  vec_t  tbl [18];
  exp_t  sbq [$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic        last_pc;
  logic        last_led;
  logic [31:0] act_rd;
  int          pulses;

  logic [1:0]  m_state;
  logic        m_ovr;
  logic        m_stepq;
  logic [31:0] m_cnt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] ctl, input logic [3:0] ev, input logic clr,
                       input logic [2:0] sel);
    {ifm.go, ifm.step_mode, ifm.step_req, ifm.resume, ifm.halt_req, ifm.led_req} = ctl;
    ifm.evt     = ev;
    ifm.cnt_clr = clr;
    ifm.cnt_sel = sel;
  endtask

  task automatic model_reset();
    m_state = 2'd0;
    m_ovr   = 1'b0;
    m_stepq = 1'b0;
    for (int i = 0; i < 8; i++) m_cnt[i] = '0;
  endtask

  function automatic logic model_pc();
    logic gate;
    gate = !ifm.halt_req || m_ovr;
    case (m_state)
      2'd1:    return gate;
      2'd2:    return ifm.step_req && !m_stepq && gate;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(input logic pc, output exp_t e);
    logic [1:0] nxt;
    if (rst) begin
      model_reset();
      e.st = 2'd0;
      e.rd = '0;
    end else begin
      e.rd = m_cnt[ifm.cnt_sel];
      nxt  = m_state;
      if (pc) m_ovr = 1'b0;
      case (m_state)
        2'd0: if (ifm.go) nxt = ifm.step_mode ? 2'd2 : 2'd1;
        2'd1: begin
          if (ifm.halt_req && !m_ovr && !pc) nxt = 2'd3;
          else if (!ifm.go)                  nxt = 2'd0;
          else if (ifm.step_mode)            nxt = 2'd2;
        end
        2'd2: begin
          if (ifm.halt_req && !m_ovr && !pc) nxt = 2'd3;
          else if (!ifm.go)                  nxt = 2'd0;
          else if (!ifm.step_mode)           nxt = 2'd1;
        end
        default: begin
          if (!ifm.go) begin
            nxt   = 2'd0;
            m_ovr = 1'b0;
          end else if (ifm.resume) begin
            nxt   = ifm.step_mode ? 2'd2 : 2'd1;
            m_ovr = 1'b1;
          end
        end
      endcase
      if (ifm.cnt_clr) begin
        for (int i = 0; i < 8; i++) m_cnt[i] = '0;
      end else begin
        m_cnt[0] = m_cnt[0] + {31'd0, pc};
        for (int i = 1; i <= 4; i++) m_cnt[i] = m_cnt[i] + {31'd0, pc & ifm.evt[i-1]};
      end
      m_stepq = ifm.step_req;
      m_state = nxt;
      e.st    = nxt;
    end
  endtask

  // Inputs were just driven; check combinational outputs, then the registered ones.
  task automatic tick();
    logic m_pc;
    exp_t e;
    #2;
    m_pc     = model_pc();
    last_pc  = ifm.pc_enable;
    last_led = ifm.led_enable;
    check("pc_enable", {31'd0, ifm.pc_enable}, {31'd0, m_pc});
    check("led_enable", {31'd0, ifm.led_enable}, {31'd0, ifm.led_req & m_pc});
    model_step(m_pc, e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      check("run_state", {30'd0, ifm.run_state}, {30'd0, e.st});
      check("cnt_rd", ifm.cnt_rd, e.rd);
    end
    act_rd = ifm.cnt_rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{6'b100000, 4'h0, 1'b0, 3'd0, 2'b00, 2'd1};
    tbl[1]  = '{6'b100001, 4'h1, 1'b0, 3'd0, 2'b11, 2'd1};
    tbl[2]  = '{6'b100010, 4'h0, 1'b0, 3'd1, 2'b00, 2'd3};
    tbl[3]  = '{6'b100011, 4'h1, 1'b0, 3'd1, 2'b00, 2'd3};
    tbl[4]  = '{6'b100110, 4'h0, 1'b0, 3'd1, 2'b00, 2'd1};
    tbl[5]  = '{6'b100010, 4'h1, 1'b0, 3'd1, 2'b10, 2'd1};
    tbl[6]  = '{6'b100000, 4'h0, 1'b0, 3'd0, 2'b10, 2'd1};
    tbl[7]  = '{6'b100010, 4'h0, 1'b0, 3'd0, 2'b00, 2'd3};
    tbl[8]  = '{6'b000010, 4'h0, 1'b0, 3'd0, 2'b00, 2'd0};
    tbl[9]  = '{6'b000001, 4'h1, 1'b0, 3'd1, 2'b00, 2'd0};
    tbl[10] = '{6'b110000, 4'h0, 1'b0, 3'd0, 2'b00, 2'd2};
    tbl[11] = '{6'b111000, 4'h1, 1'b0, 3'd1, 2'b10, 2'd2};
    tbl[12] = '{6'b111000, 4'h1, 1'b0, 3'd1, 2'b00, 2'd2};
    tbl[13] = '{6'b110000, 4'h0, 1'b0, 3'd0, 2'b00, 2'd2};
    tbl[14] = '{6'b111001, 4'h0, 1'b0, 3'd0, 2'b11, 2'd2};
    tbl[15] = '{6'b100000, 4'h0, 1'b0, 3'd7, 2'b00, 2'd1};
    tbl[16] = '{6'b100000, 4'h2, 1'b1, 3'd2, 2'b10, 2'd1};
    tbl[17] = '{6'b000000, 4'h0, 1'b0, 3'd0, 2'b10, 2'd0};

    // Power-on reset
    rst = 1'b1;
    drive(6'b000000, 4'h0, 1'b0, 3'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check("rst_state", {30'd0, ifm.run_state}, 32'd0);
    check("rst_pc_enable", {31'd0, ifm.pc_enable}, 32'd0);
    check("rst_led_enable", {31'd0, ifm.led_enable}, 32'd0);
    check("rst_cnt_rd", ifm.cnt_rd, 32'd0);
    rst = 1'b0;

    // Table: run, halt, resume-once, re-halt, idle, single-step, clear
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].ctl, tbl[i].evt, tbl[i].clr, tbl[i].sel);
      tick();
      check($sformatf("tbl%0d_pc", i), {31'd0, last_pc}, {31'd0, tbl[i].exp_pc_led[1]});
      check($sformatf("tbl%0d_led", i), {31'd0, last_led}, {31'd0, tbl[i].exp_pc_led[0]});
      check($sformatf("tbl%0d_state", i), {30'd0, ifm.run_state}, {30'd0, tbl[i].exp_nxt});
    end

    // Free run: 10 enabled cycles, then 20, on wrap and saturating 4-bit copies
    rst = 1'b1; tick(); rst = 1'b0;
    drive(6'b100000, 4'h0, 1'b0, 3'd0);
    repeat (12) tick();
    check("run10_cnt", act_rd, 32'd10);
    check("run10_state", {30'd0, ifm.run_state}, 32'd1);
    repeat (10) tick();
    check("run20_cnt", act_rd, 32'd20);
    check("sat_cnt", {28'd0, ifs.cnt_rd}, 32'd15);
    check("wrap_cnt", {28'd0, ifw.cnt_rd}, 32'd4);

    // Single step: held button gives one pulse, a new rising edge gives another
    rst = 1'b1; tick(); rst = 1'b0;
    drive(6'b110000, 4'h0, 1'b0, 3'd0);
    tick();
    pulses = 0;
    drive(6'b111000, 4'h0, 1'b0, 3'd0);
    repeat (5) begin tick(); pulses += int'(last_pc); end
    drive(6'b110000, 4'h0, 1'b0, 3'd0);
    tick(); pulses += int'(last_pc);
    drive(6'b111000, 4'h0, 1'b0, 3'd0);
    tick(); pulses += int'(last_pc);
    check("step_pulses", pulses, 32'd2);

    // Events while idle are not counted; clear beats a coincident increment
    rst = 1'b1; tick(); rst = 1'b0;
    drive(6'b000000, 4'h1, 1'b0, 3'd1);
    repeat (4) tick();
    check("idle_evt_cnt", act_rd, 32'd0);
    drive(6'b100000, 4'h1, 1'b0, 3'd1);
    repeat (3) tick();
    drive(6'b100000, 4'h1, 1'b1, 3'd1);
    tick();
    check("evt_cnt_before_clr", act_rd, 32'd2);
    drive(6'b100000, 4'h0, 1'b0, 3'd1);
    tick();
    check("evt_cnt_after_clr", act_rd, 32'd0);
    drive(6'b100000, 4'h0, 1'b0, 3'd7);
    tick();
    check("sel7_zero", act_rd, 32'd0);

    // Reset in the middle of a run clears state and counters
    drive(6'b100000, 4'h0, 1'b0, 3'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrun_rst_state", {30'd0, ifm.run_state}, 32'd0);
    check("midrun_rst_rd", act_rd, 32'd0);
    rst = 1'b0;
    drive(6'b000000, 4'h0, 1'b0, 3'd0);
    tick();
    check("midrun_rst_cnt", act_rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
